dmem_responder: RTL

- Wait-stated data-memory responder that serves the processor's data-port requests over a req/ready handshake.
- Replaces the zero-latency data memory when the core runs with stall support.
- Holds a word RAM plus a small memory-mapped I/O region: LED register and free-running cycle counter.
- Decodes address, applies byte enables, and flags illegal accesses.

---
 rtl/dmem_responder.sv | 84 ++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data memory with word RAM, LED register and cycle-counter MMIO
module dmem_responder #(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteen,
  output logic        ready,
  output logic [31:0] readdata,
  output logic        err,
  output logic [15:0] leds
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] wcnt, be_q, be;
  logic [31:0] adr_q, wd_q, cnt, rd_q, a, wd, rd;
  logic we_q, we, err_q, fire, is_ram, is_led, is_cnt, bad;
  logic [AW-1:0] idx;
  logic [31:0] ram [DEPTH];
  assign ready = state == RESP;
  assign err = err_q && state == RESP;
  assign readdata = rd_q;
  // Decode the live request in IDLE (zero-wait path) or the captured copy otherwise; pick next state
  always_comb begin
    a = state == IDLE ? dataadr : adr_q;
    wd = state == IDLE ? writedata : wd_q;
    we = state == IDLE ? memwrite : we_q;
    be = state == IDLE ? byteen : be_q;
    idx = a[AW+1:2];
    is_ram = a < 32'(DEPTH * 4);
    is_led = a == MMIO_BASE;
    is_cnt = a == MMIO_BASE + 32'd4;
    bad = a[1:0] != 2'b00 || !(is_ram || is_led || is_cnt);
    rd = (bad || we) ? 32'h0 : is_ram ? ram[idx] : is_led ? {16'h0, leds} : cnt;
    fire = (state == IDLE && req && WAIT_CYCLES == 0) || (state == BUSY && wcnt == 4'd1);
    state_nx = state == RESP ? IDLE : fire ? RESP : (state == IDLE && req) ? BUSY : state;
  end
  // State, request capture, wait countdown, free-running counter and response/LED registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wcnt <= '0;
      adr_q <= '0;
      wd_q <= '0;
      we_q <= 1'b0;
      be_q <= '0;
      cnt <= '0;
      rd_q <= '0;
      err_q <= 1'b0;
      leds <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt + 32'd1;
      if (state == IDLE && req) begin
        adr_q <= dataadr;
        wd_q <= writedata;
        we_q <= memwrite;
        be_q <= byteen;
        wcnt <= 4'(WAIT_CYCLES);
      end else if (state == BUSY) wcnt <= wcnt - 4'd1;
      if (fire) begin
        rd_q <= rd;
        err_q <= bad;
        if (we && is_led && !bad) begin
          if (be[0]) leds[7:0] <= wd[7:0];
          if (be[1]) leds[15:8] <= wd[15:8];
        end
      end
    end
  end
  // Byte-masked RAM store on the edge entering RESP; never while reset is asserted
  always_ff @(posedge clk) begin
    if (fire && we && is_ram && !bad && reset)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[idx][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule
